// File: rtl/mem_arbiter_if.sv
// Bundle of the two client request ports and the single memory port seen by mem_arbiter.
// master = arbiter side, slave = clients plus memory.
`ifndef DEFAULT_MADDR_WIDTH
`define DEFAULT_MADDR_WIDTH 16
`endif
`ifndef DEFAULT_MDATA_WIDTH
`define DEFAULT_MDATA_WIDTH 32
`endif

interface mem_arbiter_if #(
    parameter int MADDR_WIDTH = `DEFAULT_MADDR_WIDTH,
    parameter int MDATA_WIDTH = `DEFAULT_MDATA_WIDTH
) ();
    logic                   c0_read_enable;
    logic                   c0_write_enable;
    logic [MADDR_WIDTH-1:0] c0_addr;
    logic [MDATA_WIDTH-1:0] c0_write_data;
    logic                   c0_read_ready;
    logic                   c0_write_ready;
    logic [MDATA_WIDTH-1:0] c0_read_data;

    logic                   c1_read_enable;
    logic                   c1_write_enable;
    logic [MADDR_WIDTH-1:0] c1_addr;
    logic [MDATA_WIDTH-1:0] c1_write_data;
    logic                   c1_read_ready;
    logic                   c1_write_ready;
    logic [MDATA_WIDTH-1:0] c1_read_data;

    logic                   mem_read_enable;
    logic                   mem_write_enable;
    logic [MADDR_WIDTH-1:0] mem_addr;
    logic [MDATA_WIDTH-1:0] mem_write_data;
    logic                   mem_read_ready;
    logic                   mem_write_ready;
    logic [MDATA_WIDTH-1:0] mem_read_data;
    logic                   mem_timeout;

    modport master (
        input  c0_read_enable, c0_write_enable, c0_addr, c0_write_data,
        output c0_read_ready, c0_write_ready, c0_read_data,
        input  c1_read_enable, c1_write_enable, c1_addr, c1_write_data,
        output c1_read_ready, c1_write_ready, c1_read_data,
        output mem_read_enable, mem_write_enable, mem_addr, mem_write_data,
        input  mem_read_ready, mem_write_ready, mem_read_data,
        output mem_timeout
    );

    modport slave (
        output c0_read_enable, c0_write_enable, c0_addr, c0_write_data,
        input  c0_read_ready, c0_write_ready, c0_read_data,
        output c1_read_enable, c1_write_enable, c1_addr, c1_write_data,
        input  c1_read_ready, c1_write_ready, c1_read_data,
        input  mem_read_enable, mem_write_enable, mem_addr, mem_write_data,
        output mem_read_ready, mem_write_ready, mem_read_data,
        input  mem_timeout
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin two-client arbiter in front of a single-port memory with
// enable-held-until-ready handshake, per-access timeout and a one-cycle release gap.
`ifndef DEFAULT_MADDR_WIDTH
`define DEFAULT_MADDR_WIDTH 16
`endif
`ifndef DEFAULT_MDATA_WIDTH
`define DEFAULT_MDATA_WIDTH 32
`endif

module mem_arbiter #(
    parameter int MADDR_WIDTH    = `DEFAULT_MADDR_WIDTH,
    parameter int MDATA_WIDTH    = `DEFAULT_MDATA_WIDTH,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic         clock,
    input  logic         reset,
    mem_arbiter_if.master bus
);
    localparam int CNT_WIDTH = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUSY    = 2'd1,
        ST_RELEASE = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic                   last_grant_q, last_grant_d;
    logic                   owner_q, owner_d;
    logic                   op_write_q, op_write_d;
    logic [MADDR_WIDTH-1:0] addr_q, addr_d;
    logic [MDATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic [1:0]             rd_rdy_q, rd_rdy_d;
    logic [1:0]             wr_rdy_q, wr_rdy_d;
    logic [MDATA_WIDTH-1:0] rdata0_q, rdata0_d;
    logic [MDATA_WIDTH-1:0] rdata1_q, rdata1_d;
    logic                   timeout_q, timeout_d;

    logic                   req0_s, req1_s, mem_ack_s, done_s, busy_s;
    logic [MDATA_WIDTH-1:0] rvalue_s;

    assign req0_s    = bus.c0_read_enable | bus.c0_write_enable;
    assign req1_s    = bus.c1_read_enable | bus.c1_write_enable;
    assign mem_ack_s = bus.mem_read_ready | bus.mem_write_ready;
    assign done_s    = op_write_q ? bus.mem_write_ready : bus.mem_read_ready;
    assign busy_s    = (state_q == ST_BUSY);

    // Enables fall in the same cycle memory reports ready, so no second access is started.
    assign bus.mem_read_enable  = busy_s & ~op_write_q & ~mem_ack_s;
    assign bus.mem_write_enable = busy_s &  op_write_q & ~mem_ack_s;
    assign bus.mem_addr         = addr_q;
    assign bus.mem_write_data   = wdata_q;
    assign bus.mem_timeout      = timeout_q;
    assign bus.c0_read_ready    = rd_rdy_q[0];
    assign bus.c1_read_ready    = rd_rdy_q[1];
    assign bus.c0_write_ready   = wr_rdy_q[0];
    assign bus.c1_write_ready   = wr_rdy_q[1];
    assign bus.c0_read_data     = rdata0_q;
    assign bus.c1_read_data     = rdata1_q;

    // Next-state logic: grant, completion/timeout handling and release gap.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        op_write_d   = op_write_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        cnt_d        = cnt_q;
        rd_rdy_d     = 2'b00;
        wr_rdy_d     = 2'b00;
        rdata0_d     = rdata0_q;
        rdata1_d     = rdata1_q;
        timeout_d    = timeout_q;
        rvalue_s     = {MDATA_WIDTH{1'b0}};

        case (state_q)
            ST_IDLE: begin
                // A tie goes to the client that was not served last.
                if (req0_s && (!req1_s || last_grant_q)) begin
                    owner_d      = 1'b0;
                    last_grant_d = 1'b0;
                    op_write_d   = bus.c0_write_enable;
                    addr_d       = bus.c0_addr;
                    wdata_d      = bus.c0_write_data;
                    cnt_d        = {CNT_WIDTH{1'b0}};
                    state_d      = ST_BUSY;
                end else if (req1_s) begin
                    owner_d      = 1'b1;
                    last_grant_d = 1'b1;
                    op_write_d   = bus.c1_write_enable;
                    addr_d       = bus.c1_addr;
                    wdata_d      = bus.c1_write_data;
                    cnt_d        = {CNT_WIDTH{1'b0}};
                    state_d      = ST_BUSY;
                end else begin
                    state_d      = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (done_s || (cnt_q == CNT_LAST)) begin
                    if (done_s) begin
                        rvalue_s  = bus.mem_read_data;
                    end else begin
                        timeout_d = 1'b1;
                    end
                    if (op_write_q) begin
                        wr_rdy_d[owner_q] = 1'b1;
                    end else begin
                        rd_rdy_d[owner_q] = 1'b1;
                        if (owner_q) begin
                            rdata1_d = rvalue_s;
                        end else begin
                            rdata0_d = rvalue_s;
                        end
                    end
                    state_d = ST_RELEASE;
                end else begin
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                end
            end
            ST_RELEASE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset discards any in-flight access.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            op_write_q   <= 1'b0;
            addr_q       <= {MADDR_WIDTH{1'b0}};
            wdata_q      <= {MDATA_WIDTH{1'b0}};
            cnt_q        <= {CNT_WIDTH{1'b0}};
            rd_rdy_q     <= 2'b00;
            wr_rdy_q     <= 2'b00;
            rdata0_q     <= {MDATA_WIDTH{1'b0}};
            rdata1_q     <= {MDATA_WIDTH{1'b0}};
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            op_write_q   <= op_write_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            cnt_q        <= cnt_d;
            rd_rdy_q     <= rd_rdy_d;
            wr_rdy_q     <= wr_rdy_d;
            rdata0_q     <= rdata0_d;
            rdata1_q     <= rdata1_d;
            timeout_q    <= timeout_d;
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a vector table of single transactions plus
// hand-written sequences for ties, alternation, timeout and mid-access reset.
module tb_mem_arbiter;
    localparam int AW = 16;
    localparam int DW = 32;
    localparam int TO = 16;
    localparam int MEM_DELAY = 10;
    localparam int LAT = MEM_DELAY + 1;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;
    int   acc_cnt = 0;
    bit   mem_stall = 1'b0;
    int   bad_en;
    int   order_q[$];
    int   rcyc_q[$];

    mem_arbiter_if #(.MADDR_WIDTH(AW), .MDATA_WIDTH(DW)) bus ();

    mem_arbiter #(.MADDR_WIDTH(AW), .MDATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // Memory model: ready registered MEM_DELAY cycles after enable first seen.
    logic [DW-1:0] mem_arr [0:255];
    int            m_cnt;
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            bus.mem_read_ready  <= 1'b0;
            bus.mem_write_ready <= 1'b0;
            bus.mem_read_data   <= '0;
            m_cnt               <= 0;
            mem_arr[8'h40]      <= 32'hDEADBEEF;
        end else if (bus.mem_read_ready || bus.mem_write_ready) begin
            bus.mem_read_ready  <= 1'b0;
            bus.mem_write_ready <= 1'b0;
            m_cnt               <= 0;
        end else if ((bus.mem_read_enable || bus.mem_write_enable) && !mem_stall) begin
            if (m_cnt == MEM_DELAY - 1) begin
                m_cnt   <= 0;
                acc_cnt <= acc_cnt + 1;
                if (bus.mem_write_enable) begin
                    mem_arr[bus.mem_addr[7:0]] <= bus.mem_write_data;
                    bus.mem_write_ready        <= 1'b1;
                end else begin
                    bus.mem_read_data  <= mem_arr[bus.mem_addr[7:0]];
                    bus.mem_read_ready <= 1'b1;
                end
            end else begin
                m_cnt <= m_cnt + 1;
            end
        end
    end

    typedef struct {
        bit            cl;
        bit            rd;
        bit            wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        int            exp_type;   // 1 read ready, 2 write ready
        logic [DW-1:0] exp_rdata;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    task automatic drive(input bit cl, input bit rd, input bit wr,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (cl) begin
            bus.c1_read_enable = rd; bus.c1_write_enable = wr;
            bus.c1_addr = a;         bus.c1_write_data = d;
        end else begin
            bus.c0_read_enable = rd; bus.c0_write_enable = wr;
            bus.c0_addr = a;         bus.c0_write_data = d;
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(); step();
        reset = 1'b0;
        step();
    endtask

    // One transaction on one client; returns latency from grant edge, ready kind, data.
    task automatic do_txn(input bit cl, input bit rd, input bit wr,
                          input logic [AW-1:0] a, input logic [DW-1:0] d, input int budget,
                          output int lat, output int rtype, output logic [DW-1:0] rdata,
                          output int pw, output bit overlap, output logic [AW-1:0] a_seen,
                          output logic [DW-1:0] d_seen);
        int  start;
        bit  seen;
        logic own_r, own_w, oth;
        lat = -1; rtype = 0; rdata = '0; pw = 0; overlap = 1'b0; seen = 1'b0;
        a_seen = '0; d_seen = '0;
        drive(cl, rd, wr, a, d);
        start = cyc;
        for (int i = 0; i < budget; i++) begin
            step();
            if ((bus.mem_read_enable && bus.mem_read_ready) ||
                (bus.mem_write_enable && bus.mem_write_ready)) overlap = 1'b1;
            if (!seen && (bus.mem_read_enable || bus.mem_write_enable)) begin
                seen = 1'b1; a_seen = bus.mem_addr; d_seen = bus.mem_write_data;
            end
            own_r = cl ? bus.c1_read_ready  : bus.c0_read_ready;
            own_w = cl ? bus.c1_write_ready : bus.c0_write_ready;
            oth   = cl ? (bus.c0_read_ready | bus.c0_write_ready)
                       : (bus.c1_read_ready | bus.c1_write_ready);
            if (own_r || own_w || oth) begin
                lat   = cyc - start - 1;
                rtype = oth ? 3 : (own_w ? 2 : 1);
                rdata = cl ? bus.c1_read_data : bus.c0_read_data;
                drive(cl, 1'b0, 1'b0, a, d);
                step();
                own_r = cl ? bus.c1_read_ready  : bus.c0_read_ready;
                own_w = cl ? bus.c1_write_ready : bus.c0_write_ready;
                pw = (own_r || own_w) ? 2 : 1;
                break;
            end
        end
        if (lat < 0) begin
            drive(cl, 1'b0, 1'b0, a, d);
            for (int i = 0; i < TO + 4; i++) step();
        end
    endtask

    // Both clients request repeatedly; records the order and cycle of each ready.
    task automatic run_dual(input bit rd0, input bit wr0, input logic [AW-1:0] a0,
                            input logic [DW-1:0] d0, input int n0,
                            input bit rd1, input bit wr1, input logic [AW-1:0] a1,
                            input logic [DW-1:0] d1, input int n1, input int budget);
        int r0, r1;
        bit drop0, drop1;
        r0 = n0; r1 = n1; bad_en = 0;
        order_q.delete(); rcyc_q.delete();
        drive(1'b0, rd0, wr0, a0, d0);
        drive(1'b1, rd1, wr1, a1, d1);
        for (int i = 0; i < budget && (r0 > 0 || r1 > 0); i++) begin
            step();
            drop0 = 1'b0; drop1 = 1'b0;
            if (bus.c0_read_ready || bus.c0_write_ready) begin
                if (!(bus.c0_read_enable || bus.c0_write_enable)) bad_en++;
                order_q.push_back(0); rcyc_q.push_back(cyc);
                drive(1'b0, 1'b0, 1'b0, a0, d0); r0--; drop0 = 1'b1;
            end
            if (bus.c1_read_ready || bus.c1_write_ready) begin
                if (!(bus.c1_read_enable || bus.c1_write_enable)) bad_en++;
                order_q.push_back(1); rcyc_q.push_back(cyc);
                drive(1'b1, 1'b0, 1'b0, a1, d1); r1--; drop1 = 1'b1;
            end
            if (!drop0 && r0 > 0 && !bus.c0_read_enable && !bus.c0_write_enable)
                drive(1'b0, rd0, wr0, a0, d0);
            if (!drop1 && r1 > 0 && !bus.c1_read_enable && !bus.c1_write_enable)
                drive(1'b1, rd1, wr1, a1, d1);
        end
        drive(1'b0, 1'b0, 1'b0, a0, d0);
        drive(1'b1, 1'b0, 1'b0, a1, d1);
        step(); step();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int lat, rtype, pw, acc0, cnt_bad;
        bit ovl;
        logic [DW-1:0] rdata, d_seen;
        logic [AW-1:0] a_seen;

        vecs[0] = '{1'b0, 1'b1, 1'b0, 16'h0040, 32'h0,        1, 32'hDEADBEEF};
        vecs[1] = '{1'b1, 1'b0, 1'b1, 16'h0020, 32'h00001234, 2, 32'h0};
        vecs[2] = '{1'b1, 1'b1, 1'b0, 16'h0020, 32'h0,        1, 32'h00001234};
        vecs[3] = '{1'b0, 1'b0, 1'b1, 16'h0021, 32'hCAFE0001, 2, 32'h0};
        vecs[4] = '{1'b1, 1'b1, 1'b0, 16'h0021, 32'h0,        1, 32'hCAFE0001};
        vecs[5] = '{1'b1, 1'b1, 1'b1, 16'h0010, 32'h0000005A, 2, 32'h0};
        vecs[6] = '{1'b1, 1'b1, 1'b0, 16'h0010, 32'h0,        1, 32'h0000005A};
        vecs[7] = '{1'b0, 1'b1, 1'b0, 16'h0040, 32'h0,        1, 32'hDEADBEEF};

        drive(1'b0, 1'b0, 1'b0, '0, '0);
        drive(1'b1, 1'b0, 1'b0, '0, '0);
        reset = 1'b1;
        step(); step();
        chk("reset enables", {bus.mem_read_enable, bus.mem_write_enable}, 2'b00);
        chk("reset readies", {bus.c0_read_ready, bus.c0_write_ready,
                              bus.c1_read_ready, bus.c1_write_ready}, 4'b0000);
        chk("reset rdata", {bus.c0_read_data, bus.c1_read_data}, 64'h0);
        chk("reset mem bus", {bus.mem_addr, bus.mem_write_data, bus.mem_timeout}, 49'h0);
        reset = 1'b0;
        step();

        foreach (vecs[i]) begin
            acc0 = acc_cnt;
            do_txn(vecs[i].cl, vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata,
                   40, lat, rtype, rdata, pw, ovl, a_seen, d_seen);
            chk($sformatf("v%0d ready kind", i), rtype, vecs[i].exp_type);
            chk($sformatf("v%0d latency", i), lat, LAT);
            chk($sformatf("v%0d pulse width", i), pw, 1);
            chk($sformatf("v%0d accesses", i), acc_cnt - acc0, 1);
            chk($sformatf("v%0d enable/ready overlap", i), ovl, 1'b0);
            chk($sformatf("v%0d mem_addr", i), a_seen, vecs[i].addr);
            if (vecs[i].exp_type == 2)
                chk($sformatf("v%0d mem_write_data", i), d_seen, vecs[i].wdata);
            else
                chk($sformatf("v%0d read data", i), rdata, vecs[i].exp_rdata);
        end
        chk("c0 read data held", bus.c0_read_data, 32'hDEADBEEF);

        // Simultaneous first requests after reset: client 0 wins the tie.
        do_reset();
        run_dual(1'b0, 1'b1, 16'h0008, 32'h00000011, 1,
                 1'b1, 1'b0, 16'h0008, 32'h0, 1, 100);
        chk("tie count", order_q.size(), 2);
        chk("tie first", order_q[0], 0);
        chk("tie second", order_q[1], 1);
        chk("tie spacing", rcyc_q[1] - rcyc_q[0], MEM_DELAY + 3);
        chk("tie c1 data", bus.c1_read_data, 32'h00000011);
        chk("tie enable rule", bad_en, 0);

        // Continuous contention: strict alternation.
        do_reset();
        run_dual(1'b1, 1'b0, 16'h0040, 32'h0, 3,
                 1'b1, 1'b0, 16'h0010, 32'h0, 3, 200);
        chk("rr count", order_q.size(), 6);
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("rr grant %0d", i), order_q[i], i % 2);
            if (i > 0) chk($sformatf("rr spacing %0d", i), rcyc_q[i] - rcyc_q[i-1], MEM_DELAY + 3);
        end
        chk("rr enable rule", bad_en, 0);
        chk("rr c0 data", bus.c0_read_data, 32'hDEADBEEF);
        chk("rr c1 data", bus.c1_read_data, 32'h0000005A);

        // Stalled memory: timeout returns zero data and sets the sticky flag.
        mem_stall = 1'b1;
        acc0 = acc_cnt;
        do_txn(1'b0, 1'b1, 1'b0, 16'h0040, 32'h0, 40, lat, rtype, rdata, pw, ovl, a_seen, d_seen);
        mem_stall = 1'b0;
        chk("to ready kind", rtype, 1);
        chk("to latency", lat, TO);
        chk("to data", rdata, 32'h0);
        chk("to flag", bus.mem_timeout, 1'b1);
        chk("to accesses", acc_cnt - acc0, 0);
        do_txn(1'b1, 1'b1, 1'b0, 16'h0010, 32'h0, 40, lat, rtype, rdata, pw, ovl, a_seen, d_seen);
        chk("post-to data", rdata, 32'h0000005A);
        chk("post-to latency", lat, LAT);
        chk("to flag sticky", bus.mem_timeout, 1'b1);

        // Reset five cycles into a BUSY write.
        drive(1'b0, 1'b0, 1'b1, 16'h0030, 32'h00000077);
        for (int i = 0; i < 6; i++) step();
        chk("pre-reset write enable", bus.mem_write_enable, 1'b1);
        #3;
        reset = 1'b1;
        #1;
        chk("async drop", {bus.mem_read_enable, bus.mem_write_enable}, 2'b00);
        chk("reset clears timeout", bus.mem_timeout, 1'b0);
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        cnt_bad = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (bus.c0_write_ready || bus.c0_read_ready) cnt_bad++;
        end
        reset = 1'b0;
        for (int i = 0; i < 15; i++) begin
            step();
            if (bus.c0_write_ready || bus.c0_read_ready || bus.mem_write_enable) cnt_bad++;
        end
        chk("no pulse after reset", cnt_bad, 0);
        do_txn(1'b0, 1'b1, 1'b0, 16'h0040, 32'h0, 40, lat, rtype, rdata, pw, ovl, a_seen, d_seen);
        chk("recover kind", rtype, 1);
        chk("recover latency", lat, LAT);
        chk("recover data", rdata, 32'hDEADBEEF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
